// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared constants and types for the multiply/divide unit
package mul_div_unit_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    function automatic logic is_md_op(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - execute-stage to multiply/divide unit handshake bundle
interface mul_div_unit_if;
    import mul_div_unit_pkg::*;

    logic              start;
    logic [5:0]        Function_opcode;
    logic [DATA_W-1:0] Read_data_1;
    logic [DATA_W-1:0] Read_data_2;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] HI;
    logic [DATA_W-1:0] LO;
    logic [DATA_W-1:0] Mf_Result;

    modport master (
        output start, Function_opcode, Read_data_1, Read_data_2,
        input  busy, done, HI, LO, Mf_Result
    );

    modport slave (
        input  start, Function_opcode, Read_data_1, Read_data_2,
        output busy, done, HI, LO, Mf_Result
    );

endinterface

// File: rtl/mul_div_unit_md_iter_core.sv
// rtl/mul_div_unit_md_iter_core.sv - one shift-add or restoring shift-subtract step per cycle
module md_iter_core #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic         step,
    input  logic         div_mode,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic [W-1:0] acc_hi,
    output logic [W-1:0] acc_lo
);

    logic [W-1:0] hi_q;
    logic [W-1:0] lo_q;
    logic [W-1:0] b_q;
    logic         div_q;

    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole 64-bit pair right.
    logic [W:0] mul_sum;
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});

    // Divide: shift the next dividend bit into the partial remainder and keep
    // the difference only when it does not go negative. The difference always
    // fits in W bits when taken, so modulo-W subtraction is exact.
    logic [W:0]   div_shift;
    logic [W-1:0] div_diff;
    logic         div_ok;
    assign div_shift = {hi_q, lo_q[W-1]};
    assign div_diff  = div_shift[W-1:0] - b_q;
    assign div_ok    = div_shift >= {1'b0, b_q};

    // Load seeds the pair (multiplier or dividend in the low half); each step advances one bit.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            hi_q  <= '0;
            lo_q  <= div_mode ? op_a : op_b;
            b_q   <= div_mode ? op_b : op_a;
            div_q <= div_mode;
        end else if (step) begin
            if (div_q) begin
                hi_q <= div_ok ? div_diff : div_shift[W-1:0];
                lo_q <= {lo_q[W-2:0], div_ok};
            end else begin
                hi_q <= mul_sum[W:1];
                lo_q <= {mul_sum[0], lo_q[W-1:1]};
            end
        end
    end

    assign acc_hi = hi_q;
    assign acc_lo = lo_q;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit owning the HI/LO registers
module mul_div_unit #(
    parameter int DATA_W = 32,
    parameter int ITER   = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    mul_div_unit_if.slave bus
);
    import mul_div_unit_pkg::*;

    localparam int CNT_W = $clog2(ITER);

    md_state_e state_q;
    md_state_e state_d;

    logic [CNT_W-1:0]  iter_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] a_raw_q;
    logic              div_q;
    logic              res_neg_q;
    logic              rem_neg_q;
    logic              div_zero_q;

    logic              idle_start;
    logic              accept;
    logic              signed_op;
    logic              div_op;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;

    logic [DATA_W-1:0]   core_hi;
    logic [DATA_W-1:0]   core_lo;
    logic [2*DATA_W-1:0] prod_raw;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    assign idle_start = (state_q == IDLE) && bus.start;
    assign accept     = idle_start && is_md_op(bus.Function_opcode);
    assign signed_op  = (bus.Function_opcode == FN_MULT) || (bus.Function_opcode == FN_DIV);
    assign div_op     = (bus.Function_opcode == FN_DIV) || (bus.Function_opcode == FN_DIVU);
    assign a_neg      = signed_op && bus.Read_data_1[DATA_W-1];
    assign b_neg      = signed_op && bus.Read_data_2[DATA_W-1];
    assign mag_a      = a_neg ? -bus.Read_data_1 : bus.Read_data_1;
    assign mag_b      = b_neg ? -bus.Read_data_2 : bus.Read_data_2;

    md_iter_core #(.W(DATA_W)) u_core (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (accept),
        .step     (state_q == CALC),
        .div_mode (div_op),
        .op_a     (mag_a),
        .op_b     (mag_b),
        .acc_hi   (core_hi),
        .acc_lo   (core_lo)
    );

    // The core works on magnitudes; the sign is restored once, after the last step.
    assign prod_raw = {core_hi, core_lo};
    assign prod_fix = res_neg_q ? -prod_raw : prod_raw;
    assign quo_fix  = res_neg_q ? -core_lo : core_lo;
    assign rem_fix  = rem_neg_q ? -core_hi : core_hi;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> CALC for ITER cycles -> FIX -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = CALC;
            CALC: if (iter_q == CNT_W'(ITER - 1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Iteration counter and per-operation attributes captured at accept.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            iter_q     <= '0;
            a_raw_q    <= '0;
            div_q      <= 1'b0;
            res_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (accept) begin
            iter_q     <= '0;
            a_raw_q    <= bus.Read_data_1;
            div_q      <= div_op;
            res_neg_q  <= a_neg ^ b_neg;
            rem_neg_q  <= a_neg;
            div_zero_q <= div_op && (bus.Read_data_2 == '0);
        end else if (state_q == CALC) begin
            iter_q <= iter_q + 1'b1;
        end
    end

    // HI/LO change only on reset, on the FIX cycle, or on an idle mthi/mtlo.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state_q == FIX) begin
            if (!div_q) begin
                hi_q <= prod_fix[2*DATA_W-1:DATA_W];
                lo_q <= prod_fix[DATA_W-1:0];
            end else if (div_zero_q) begin
                hi_q <= a_raw_q;
                lo_q <= '1;
            end else begin
                hi_q <= rem_fix;
                lo_q <= quo_fix;
            end
        end else if (idle_start && (bus.Function_opcode == FN_MTHI)) begin
            hi_q <= bus.Read_data_1;
        end else if (idle_start && (bus.Function_opcode == FN_MTLO)) begin
            lo_q <= bus.Read_data_1;
        end
    end

    // mfhi/mflo read port for the writeback mux.
    always_comb begin
        bus.Mf_Result = '0;
        if (bus.Function_opcode == FN_MFHI) bus.Mf_Result = hi_q;
        else if (bus.Function_opcode == FN_MFLO) bus.Mf_Result = lo_q;
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide responder that owns the HI/LO registers of the Minisys-style CPU.
- The execute stage issues mult/multu/div/divu through a start/busy/done handshake. The operands are the same Read_data_1 (rs) and Read_data_2 (rt) the ALU uses.
- The unit also serves mfhi/mflo reads and mthi/mtlo writes.
- Sits beside executs32; its Mf_Result is muxed into the writeback path by the controller.

Parameters:
- DATA_W, 32, operand and HI/LO width; only 32 is supported.
- ITER, 32, shift/add or shift/subtract iterations; must equal DATA_W.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- Function_opcode  in  6  instruction[5:0]; selects the operation
- Read_data_1  in  32  rs operand (multiplicand/dividend, or mthi/mtlo source)
- Read_data_2  in  32  rt operand (multiplier/divisor)
- busy  out  1  high from the cycle after accept through the done cycle
- done  out  1  one-cycle pulse; HI/LO already hold the new values
- HI  out  32  HI register
- LO  out  32  LO register
- Mf_Result  out  32  combinational: HI for mfhi (0x10), LO for mflo (0x12), else 0

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE; HI=LO=0; busy=done=0; all internal registers cleared.
  - Reset mid-operation aborts the operation; no partial result reaches HI/LO.
- Opcodes:
  - 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu: multi-cycle.
  - 0x11 mthi, 0x13 mtlo: single-cycle write.
  - 0x10 mfhi, 0x12 mflo: read-only.
  - Any other opcode with start=1 is ignored.
- Accept (cycle N, state IDLE, start=1, opcode is mult/multu/div/divu):
  - Latch both operands and the opcode.
  - Signed ops latch magnitudes plus the result-sign bits: quotient/product sign = a[31]^b[31]; remainder sign = a[31].
- mthi/mtlo: in IDLE with start=1, HI (or LO) <= Read_data_1 at that edge; busy stays 0; no done pulse.
- States:
  - IDLE -> CALC on accept.
  - CALC runs ITER cycles: multiply = shift-add on a 64-bit accumulator; divide = restoring shift-subtract. Iteration counter counts 0..ITER-1.
  - CALC -> FIX after the last iteration. FIX applies two's-complement sign correction and writes HI/LO.
  - FIX -> DONE. DONE asserts done=1 for one cycle.
  - DONE -> IDLE.
- Latency: done is high in cycle N+34; busy is high in cycles N+1..N+34; new start is accepted from cycle N+35.
- Result placement: multiply → HI = product[63:32], LO = product[31:0]. Divide → LO = quotient, HI = remainder.
- Boundaries:
  - start while busy: ignored entirely, including mthi/mtlo.
  - Divide by zero: same latency; LO=0xFFFFFFFF, HI=Read_data_1 as latched.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0; no trap.
  - mult with either operand 0: HI=LO=0.
  - Operand inputs changing during CALC have no effect.
  - HI/LO change only in FIX, on mthi/mtlo, or on reset; they are stable at every other time.

Decomposition:
- Shared package holds:
  - Funct constants: FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU.
  - The 2-bit state encoding: IDLE, CALC, FIX, DONE.
  - The DATA_W constant.
- One sub-module is natural: md_iter_core, the datapath that performs one shift-add or shift-subtract step per cycle over a 64-bit register pair, selected by a mul/div flag.
- mul_div_unit keeps the FSM, sign handling, HI/LO and the handshake.

Test Plan:
- multu 0xFFFFFFFF × 0xFFFFFFFF, start at cycle 0 -> done=1 only at cycle 34; HI=0xFFFFFFFE, LO=0x00000001; busy high in cycles 1..34.
- mult 0xFFFFFFFD (-3) × 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; a 0x80000000 × 0x80000000 mult -> HI=0x40000000, LO=0.
- div 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/2 -> LO=3, HI=1.
- divu 10 / 0 -> LO=0xFFFFFFFF, HI=0x0000000A after 34 cycles; then div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mtlo with Read_data_1=0x12345678 in IDLE; next cycle mflo -> Mf_Result=0x12345678. mthi issued while busy -> HI unchanged.
- Start mult 5×6, pulse reset_n=0 at cycle 10 -> the next cycle shows busy=0, HI=LO=0, no done pulse; a fresh multu 5×6 then gives LO=30, HI=0.
